// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, ALU, accumulator-source and FSM state definitions (CPU_CTRL_STEP_EN adds ST_PAUSE)
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOADI = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_MOV   = 4'h8;
    localparam logic [3:0] OP_LOADR = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_SHL   = 4'hC;
    localparam logic [3:0] OP_SHR   = 4'hD;
    localparam logic [3:0] OP_RSVD  = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    localparam logic [1:0] ACC_SRC_ALU = 2'd0;
    localparam logic [1:0] ACC_SRC_IMM = 2'd1;
    localparam logic [1:0] ACC_SRC_REG = 2'd2;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
`ifdef CPU_CTRL_STEP_EN
        ST_HALT    = 3'd4,
        ST_PAUSE   = 3'd5
`else
        ST_HALT    = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// rtl/cpu_ctrl_decode.sv - combinational opcode-to-execute-strobe map, gated by EXECUTE in the top
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic       i_zero,
    output logic       o_load_pc,
    output logic       o_load_acc,
    output logic       o_load_reg,
    output logic [1:0] o_sel_acc,
    output logic [2:0] o_alu_op,
    output logic       o_is_halt
);

    always_comb begin
        o_load_pc  = 1'b0;
        o_load_acc = 1'b0;
        o_load_reg = 1'b0;
        o_sel_acc  = ACC_SRC_ALU;
        o_alu_op   = ALU_ADD;
        o_is_halt  = 1'b0;
        case (i_opcode)
            OP_LOADI: begin o_load_acc = 1'b1; o_sel_acc = ACC_SRC_IMM; end
            OP_ADD:   begin o_load_acc = 1'b1; o_alu_op = ALU_ADD; end
            OP_SUB:   begin o_load_acc = 1'b1; o_alu_op = ALU_SUB; end
            OP_AND:   begin o_load_acc = 1'b1; o_alu_op = ALU_AND; end
            OP_OR:    begin o_load_acc = 1'b1; o_alu_op = ALU_OR;  end
            OP_XOR:   begin o_load_acc = 1'b1; o_alu_op = ALU_XOR; end
            OP_NOT:   begin o_load_acc = 1'b1; o_alu_op = ALU_NOT; end
            OP_MOV:   o_load_reg = 1'b1;
            OP_LOADR: begin o_load_acc = 1'b1; o_sel_acc = ACC_SRC_REG; end
            OP_JMP:   o_load_pc = 1'b1;
            OP_JZ:    o_load_pc = i_zero;
            OP_SHL:   begin o_load_acc = 1'b1; o_alu_op = ALU_SHL; end
            OP_SHR:   begin o_load_acc = 1'b1; o_alu_op = ALU_SHR; end
            OP_HALT:  o_is_halt = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - fetch/decode/execute control FSM; CPU_CTRL_STEP_EN adds single-step PAUSE
module cpu_controller
    import cpu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       zero,
`ifdef CPU_CTRL_STEP_EN
    input  logic       step_req,
`endif
    output logic       LoadIR,
    output logic       IncPC,
    output logic       LoadPC,
    output logic       LoadAcc,
    output logic       LoadReg,
    output logic [1:0] SelAcc,
    output logic [2:0] ALUop,
    output logic       halted
);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_load_pc;
    logic       w_load_acc;
    logic       w_load_reg;
    logic [1:0] w_sel_acc;
    logic [2:0] w_alu_op;
    logic       w_is_halt;

    cpu_ctrl_decode u_decode (
        .i_opcode   (opcode),
        .i_zero     (zero),
        .o_load_pc  (w_load_pc),
        .o_load_acc (w_load_acc),
        .o_load_reg (w_load_reg),
        .o_sel_acc  (w_sel_acc),
        .o_alu_op   (w_alu_op),
        .o_is_halt  (w_is_halt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_INIT;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT:    w_next_state = ST_FETCH;
            ST_FETCH:   w_next_state = ST_DECODE;
            ST_DECODE:  w_next_state = ST_EXECUTE;
`ifdef CPU_CTRL_STEP_EN
            ST_EXECUTE: w_next_state = w_is_halt ? ST_HALT : ST_PAUSE;
            ST_PAUSE:   w_next_state = step_req ? ST_FETCH : ST_PAUSE;
`else
            ST_EXECUTE: w_next_state = w_is_halt ? ST_HALT : ST_FETCH;
`endif
            ST_HALT:    w_next_state = ST_HALT;
            default:    w_next_state = ST_INIT;
        endcase
    end

    // Decoder strobes only reach the datapath during EXECUTE.
    always_comb begin
        LoadIR  = 1'b0;
        IncPC   = 1'b0;
        LoadPC  = 1'b0;
        LoadAcc = 1'b0;
        LoadReg = 1'b0;
        SelAcc  = ACC_SRC_ALU;
        ALUop   = ALU_ADD;
        halted  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                LoadIR = 1'b1;
                IncPC  = 1'b1;
            end
            ST_EXECUTE: begin
                LoadPC  = w_load_pc;
                LoadAcc = w_load_acc;
                LoadReg = w_load_reg;
                SelAcc  = w_sel_acc;
                ALUop   = w_alu_op;
            end
            ST_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed self-checking bench for cpu_controller (CPU_CTRL_STEP_EN aware)
module tb_cpu_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       zero;
    logic       step_req;
    logic       LoadIR, IncPC, LoadPC, LoadAcc, LoadReg, halted;
    logic [1:0] SelAcc;
    logic [2:0] ALUop;
    logic [10:0] w_obs;

    int n_checks = 0;
    int n_errors = 0;

    // {halted, LoadIR, IncPC, LoadPC, LoadAcc, LoadReg, SelAcc[1:0], ALUop[2:0]}
    localparam logic [10:0] E_NONE  = 11'h000;
    localparam logic [10:0] E_FETCH = 11'h300;
    localparam logic [10:0] E_HALT  = 11'h400;
    localparam logic [10:0] E_EXEC [0:14] = '{
        11'h000, 11'h048, 11'h040, 11'h041, 11'h042, 11'h043, 11'h044, 11'h045,
        11'h020, 11'h050, 11'h080, 11'h080, 11'h046, 11'h047, 11'h000
    };

    always #5 clock = ~clock;

    assign w_obs = {halted, LoadIR, IncPC, LoadPC, LoadAcc, LoadReg, SelAcc, ALUop};

    cpu_controller dut (
        .clock    (clock),
        .reset    (reset),
        .opcode   (opcode),
        .zero     (zero),
`ifdef CPU_CTRL_STEP_EN
        .step_req (step_req),
`endif
        .LoadIR   (LoadIR),
        .IncPC    (IncPC),
        .LoadPC   (LoadPC),
        .LoadAcc  (LoadAcc),
        .LoadReg  (LoadReg),
        .SelAcc   (SelAcc),
        .ALUop    (ALUop),
        .halted   (halted)
    );

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Entered in a FETCH cycle; leaves in the following FETCH cycle.
    task automatic run_instr(input logic [3:0] op, input logic z, input logic [10:0] exp, input string tag);
        check({tag, "_fetch"}, w_obs, E_FETCH);
        tick();
        opcode = op;
        zero   = z;
        #1 check({tag, "_decode"}, w_obs, E_NONE);
        tick();
        check({tag, "_exec"}, w_obs, exp);
        tick();
`ifdef CPU_CTRL_STEP_EN
        check({tag, "_pause"}, w_obs, E_NONE);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
`endif
    endtask

    initial begin
        reset    = 1'b1;
        opcode   = 4'h0;
        zero     = 1'b0;
        step_req = 1'b0;
        tick();
        check("reset_held", w_obs, E_NONE);
        reset = 1'b0;
        #1 check("init", w_obs, E_NONE);
        tick();

        run_instr(4'h0, 1'b0, E_NONE, "nop0");
        run_instr(4'h0, 1'b0, E_NONE, "nop1");
        for (int i = 0; i < 15; i++)
            run_instr(i[3:0], 1'b1, E_EXEC[i], $sformatf("op%0h", i));
        run_instr(4'hB, 1'b0, E_NONE, "jz_nz");

`ifdef CPU_CTRL_STEP_EN
        // PAUSE holds without a step pulse.
        check("pl_fetch", w_obs, E_FETCH);
        tick();
        opcode = 4'h1;
        tick();
        check("pl_exec", w_obs, 11'h048);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pl_hold", w_obs, E_NONE);
        end
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("pl_step_fetch", w_obs, E_FETCH);
`endif

        check("halt_fetch", w_obs, E_FETCH);
        tick();
        opcode = 4'hF;
        #1 check("halt_decode", w_obs, E_NONE);
        tick();
        check("halt_exec", w_obs, E_NONE);
        step_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            opcode = 4'(i);
            zero   = i[0];
            #1 check("halt_sticky", w_obs, E_HALT);
        end
        step_req = 1'b0;
        #1 reset = 1'b1;
        #1 check("halt_reset", w_obs, E_NONE);
        tick();
        reset = 1'b0;
        #1 check("halt_reinit", w_obs, E_NONE);
        tick();
        check("halt_refetch", w_obs, E_FETCH);

        // Reset during DECODE of MOV must suppress LoadReg.
        tick();
        opcode = 4'h8;
        #1 check("mov_decode", w_obs, E_NONE);
        reset = 1'b1;
        #1 check("mov_abort", w_obs, E_NONE);
        tick();
        check("mov_abort_hold", w_obs, E_NONE);
        reset = 1'b0;
        #1 check("mov_reinit", w_obs, E_NONE);
        tick();
        run_instr(4'h8, 1'b0, 11'h020, "mov_after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Fetch/decode/execute control FSM for the 8-bit accumulator CPU. It consumes the 4-bit opcode held by the instruction register and produces every datapath strobe: IR load, PC increment/load, accumulator and register-file writes, ALU operation and accumulator source select. It sits between the instruction register and the PC/ALU/register-file datapath. Each instruction takes three cycles.

## Interface
Parameters: none.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- opcode  in  4  opcode from the instruction register.
- zero  in  1  accumulator-zero flag from the datapath.
- LoadIR  out  1  instruction register load strobe.
- IncPC  out  1  PC increment strobe.
- LoadPC  out  1  PC load from IR data field (jump).
- LoadAcc  out  1  accumulator write strobe.
- LoadReg  out  1  register-file write strobe; index is the IR data field.
- SelAcc  out  2  accumulator source: 0 ALU, 1 immediate, 2 register file.
- ALUop  out  3  ALU operation.
- halted  out  1  high while in HALT.
- step_req  in  1  present only with CPU_CTRL_STEP_EN; single-step advance pulse.

## Operation
- States: INIT, FETCH, DECODE, EXECUTE, HALT, plus PAUSE with CPU_CTRL_STEP_EN.
- Transitions:
  - INIT → FETCH → DECODE → EXECUTE → FETCH.
  - EXECUTE with HALT opcode → HALT.
  - HALT is sticky until reset.
- Outputs are combinational from state (and opcode in EXECUTE). All outputs are 0 in INIT, DECODE, HALT and PAUSE, except halted=1 in HALT.
- FETCH: LoadIR=1, IncPC=1.
- EXECUTE, by opcode:
  - 0x0 NOP: no strobes.
  - 0x1 LOADI: LoadAcc=1, SelAcc=1.
  - 0x2 ADD, 0x3 SUB, 0x4 AND, 0x5 OR, 0x6 XOR: LoadAcc=1, SelAcc=0. ALUop = 0, 1, 2, 3, 4 respectively.
  - 0x7 NOT: LoadAcc=1, SelAcc=0, ALUop=5.
  - 0x8 MOV: LoadReg=1.
  - 0x9 LOADR: LoadAcc=1, SelAcc=2.
  - 0xA JMP: LoadPC=1.
  - 0xB JZ: LoadPC=zero.
  - 0xC SHL: LoadAcc=1, SelAcc=0, ALUop=6.
  - 0xD SHR: LoadAcc=1, SelAcc=0, ALUop=7.
  - 0xE reserved: executes as NOP.
  - 0xF HALT: no strobes; next state HALT.
- ALUop and SelAcc are 0 whenever LoadAcc=0.
- At most one of LoadIR, LoadPC, LoadAcc, LoadReg is high in any cycle.
- IncPC and LoadPC are never high together.

## Timing
- Reset asserted: state=INIT immediately, all outputs 0. Reset mid-instruction aborts with no further strobes.
- After reset deassert:
  - Cycle 0: INIT.
  - Cycle 1: FETCH.
  - Cycle 2: DECODE. The opcode is valid from the IR here, because the IR loads on the FETCH→DECODE edge.
  - Cycle 3: EXECUTE.
  - Cycle 4: next FETCH.
- Instruction latency is 3 cycles; throughput is 1 instruction per 3 cycles.
- zero is sampled combinationally during EXECUTE only.
- The opcode must stay stable from DECODE through EXECUTE; the FSM relies on LoadIR being low outside FETCH.

## Configuration
- CPU_CTRL_STEP_EN defined:
  - step_req port exists.
  - EXECUTE (non-HALT) → PAUSE instead of FETCH.
  - PAUSE → FETCH on the cycle after step_req is sampled high; otherwise PAUSE holds with all strobes 0.
  - step_req is ignored in every other state, HALT included.
- Undefined: no step_req port, no PAUSE state, free-running FETCH/DECODE/EXECUTE.

## Structure
- Shared package cpu_pkg:
  - opcode constants (OP_NOP … OP_HALT);
  - ALU op constants (ALU_ADD=0 … ALU_SHR=7);
  - SelAcc constants (ACC_SRC_ALU/IMM/REG);
  - FSM state enum.
- Sub-module cpu_ctrl_decode: purely combinational map from opcode + zero to execute-cycle strobes, gated by the EXECUTE state in the top module.
- The top module holds the state register and next-state logic.

## Test plan
- Reset release, opcode=0x0 → INIT for 1 cycle with all outputs 0. FETCH follows with LoadIR=IncPC=1. NOP EXECUTE asserts no strobes. Pattern repeats every 3 cycles.
- opcode=0x2 held → EXECUTE cycle shows LoadAcc=1, SelAcc=0, ALUop=0; opcode=0x1 → LoadAcc=1, SelAcc=1, ALUop=0.
- opcode=0xB: with zero=1, EXECUTE has LoadPC=1 and IncPC=0; with zero=0, no strobes.
- opcode=0xF → halted=1 from the cycle after EXECUTE and stays high for 20 cycles. Changing opcode causes no strobes. Reset returns to INIT with halted=0.
- Reset asserted during DECODE of opcode 0x8 → LoadReg is never asserted; the FSM restarts at INIT.
- CPU_CTRL_STEP_EN, opcode 0x1 → FSM stays in PAUSE after EXECUTE with all strobes 0. A 1-cycle step_req pulse → FETCH on the next cycle. A step_req held in HALT has no effect.
